// File: rtl/in_service_control_pkg.sv
// Shared types for the 8259A in-service stage: FSM states,
// OCW2 command codes and a one-hot encoder.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        ACK2
    } state_t;

    localparam logic [2:0] OCW2_CLR_AROT = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI   = 3'b001;
    localparam logic [2:0] OCW2_NOP      = 3'b010;
    localparam logic [2:0] OCW2_S_EOI    = 3'b011;
    localparam logic [2:0] OCW2_SET_AROT = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRI  = 3'b110;
    localparam logic [2:0] OCW2_ROT_S    = 3'b111;

    function automatic logic [2:0] encode(input logic [7:0] onehot);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) r = r | i[2:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/in_service_control_if.sv
// Bundle between the PIC register/resolver side and the
// in-service control stage, plus the CPU INTA/data bus pins.
interface in_service_control_if;

    logic [7:0] interrupt;
    logic       inta_low;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       ocw2_valid;
    logic [2:0] ocw2_cmd;
    logic [2:0] ocw2_level;
    logic       interrupt_out;
    logic [7:0] in_service_register;
    logic [2:0] priority_rotate;
    logic [7:0] clear_interrupt_request;
    logic [7:0] data_bus_out;
    logic       data_bus_drive;

    modport master (
        output interrupt, inta_low, vector_base, auto_eoi,
        output ocw2_valid, ocw2_cmd, ocw2_level,
        input  interrupt_out, in_service_register,
        input  priority_rotate, clear_interrupt_request,
        input  data_bus_out, data_bus_drive
    );

    modport slave (
        input  interrupt, inta_low, vector_base, auto_eoi,
        input  ocw2_valid, ocw2_cmd, ocw2_level,
        output interrupt_out, in_service_register,
        output priority_rotate, clear_interrupt_request,
        output data_bus_out, data_bus_drive
    );

endinterface

// File: rtl/in_service_control_isr_priority_scan.sv
// Finds the highest-priority in-service level, scanning upward
// from the level just above the lowest-priority one.
module isr_priority_scan (
    input  logic [7:0] isr,
    input  logic [2:0] rotate,
    output logic [2:0] level,
    output logic       valid
);

    logic [2:0] idx;

    always_comb begin
        level = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= 8; i++) begin
            idx = rotate + i[2:0];
            if (!valid && isr[idx]) begin
                valid = 1'b1;
                level = idx;
            end
        end
    end

endmodule

// File: rtl/in_service_control.sv
// INT/INTA sequencing, In-Service Register, rotating priority
// and OCW2 EOI handling for the 8259A model.
module in_service_control
    import pic_pkg::*;
#(
    parameter int SPURIOUS_LEVEL = 7
) (
    input logic           clock,
    input logic           reset,
    in_service_control_if.slave bus
);

    state_t     state;
    logic       inta_low_q;
    logic [2:0] ack_level;
    logic       spurious;
    logic       auto_rotate;
    logic [7:0] isr;
    logic [2:0] rot;
    logic       int_out;
    logic [7:0] clr;
    logic [7:0] dout;
    logic       drive;

    logic       inta_rise;
    logic [2:0] scan_level;
    logic       scan_valid;
    logic [7:0] ocw_clear;
    logic [7:0] aeoi_clear;
    logic [7:0] set_mask;
    logic       ack_end;

    assign inta_rise = bus.inta_low & ~inta_low_q;
    assign ack_end   = (state == ACK2) & ~bus.inta_low;

    isr_priority_scan u_scan (
        .isr    (isr),
        .rotate (rot),
        .level  (scan_level),
        .valid  (scan_valid)
    );

    // OCW2 clears are judged against the ISR before this cycle's update
    always_comb begin
        ocw_clear = '0;
        if (bus.ocw2_valid) begin
            case (bus.ocw2_cmd)
                OCW2_NS_EOI, OCW2_ROT_NS:
                    if (scan_valid) ocw_clear[scan_level] = 1'b1;
                OCW2_S_EOI, OCW2_ROT_S:
                    ocw_clear[bus.ocw2_level] = 1'b1;
                default: ocw_clear = '0;
            endcase
        end
    end

    always_comb begin
        set_mask   = '0;
        aeoi_clear = '0;
        if (state == IDLE && inta_rise && |bus.interrupt)
            set_mask = 8'b1 << encode(bus.interrupt);
        if (ack_end && bus.auto_eoi && !spurious)
            aeoi_clear = 8'b1 << ack_level;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            inta_low_q  <= 1'b0;
            ack_level   <= '0;
            spurious    <= 1'b0;
            auto_rotate <= 1'b0;
            isr         <= '0;
            rot         <= 3'd7;
            int_out     <= 1'b0;
            clr         <= '0;
            dout        <= '0;
            drive       <= 1'b0;
        end else begin
            inta_low_q <= bus.inta_low;
            clr        <= '0;
            isr        <= (isr & ~(ocw_clear | aeoi_clear))
                          | set_mask;
            case (state)
                IDLE: begin
                    int_out <= |bus.interrupt;
                    if (inta_rise) begin
                        ack_level <= |bus.interrupt
                                     ? encode(bus.interrupt)
                                     : 3'(SPURIOUS_LEVEL);
                        spurious  <= ~|bus.interrupt;
                        clr       <= set_mask;
                        int_out   <= 1'b0;
                        state     <= ACK1;
                    end
                end
                ACK1: begin
                    int_out <= 1'b0;
                    if (inta_rise) begin
                        dout  <= {bus.vector_base, ack_level};
                        drive <= 1'b1;
                        state <= ACK2;
                    end
                end
                ACK2: begin
                    if (bus.inta_low) begin
                        dout <= {bus.vector_base, ack_level};
                    end else begin
                        drive <= 1'b0;
                        state <= IDLE;
                        if (bus.auto_eoi && auto_rotate && !spurious)
                            rot <= ack_level;
                    end
                end
                default: state <= IDLE;
            endcase
            // a same-cycle OCW2 rotate takes precedence over AEOI rotate
            if (bus.ocw2_valid) begin
                case (bus.ocw2_cmd)
                    OCW2_ROT_NS:
                        if (scan_valid) rot <= scan_level;
                    OCW2_ROT_S, OCW2_SET_PRI:
                        rot <= bus.ocw2_level;
                    OCW2_SET_AROT: auto_rotate <= 1'b1;
                    OCW2_CLR_AROT: auto_rotate <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign bus.interrupt_out           = int_out;
    assign bus.in_service_register     = isr;
    assign bus.priority_rotate         = rot;
    assign bus.clear_interrupt_request = clr;
    assign bus.data_bus_out            = dout;
    assign bus.data_bus_drive          = drive;

endmodule

// File: tb/tb_in_service_control.sv
// Table-driven and randomized checks of in_service_control
// against a transaction-level model of the ISR and priority.
module tb_in_service_control;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    in_service_control_if bus();

    in_service_control dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    bit [7:0] m_isr;
    int       m_rot;
    bit       m_arot;

    typedef struct {
        bit       is_ack;
        bit       aeoi;
        bit [7:0] data;
        bit [7:0] exp_isr;
        bit [2:0] exp_rot;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input int act,
                         input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // distance from the highest-priority slot decides the winner
    function automatic int ns_level();
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = 99;
        for (int l = 0; l < 8; l++) begin
            d = (l - m_rot - 1 + 16) % 8;
            if (m_isr[l] && d < bestd) begin
                bestd = d;
                best  = l;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_isr  = '0;
        m_rot  = 7;
        m_arot = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_isr"}, bus.in_service_register, m_isr);
        check({tag, "_rot"}, bus.priority_rotate, m_rot);
    endtask

    task automatic ocw(input bit [2:0] cmd, input bit [2:0] lvl);
        int h;
        bus.ocw2_valid = 1'b1;
        bus.ocw2_cmd   = cmd;
        bus.ocw2_level = lvl;
        h = ns_level();
        step();
        bus.ocw2_valid = 1'b0;
        case (cmd)
            3'b001: if (h >= 0) m_isr[h] = 1'b0;
            3'b011: m_isr[lvl] = 1'b0;
            3'b101: if (h >= 0) begin
                m_isr[h] = 1'b0;
                m_rot    = h;
            end
            3'b111: begin
                m_isr[lvl] = 1'b0;
                m_rot      = lvl;
            end
            3'b100: m_arot = 1'b1;
            3'b000: m_arot = 1'b0;
            3'b110: m_rot = lvl;
            default: ;
        endcase
        check_state("ocw");
    endtask

    task automatic ack(input bit [7:0] irq, input bit aeoi);
        int  lvl;
        bit  sp;
        sp  = (irq == 0);
        lvl = sp ? 7 : $clog2(irq);
        bus.auto_eoi  = aeoi;
        bus.interrupt = irq;
        step();
        check("int_out_req", bus.interrupt_out, !sp);
        bus.inta_low = 1'b1;
        step();
        if (!sp) m_isr[lvl] = 1'b1;
        check("ack1_isr", bus.in_service_register, m_isr);
        check("ack1_clr", bus.clear_interrupt_request, irq);
        check("ack1_drive", bus.data_bus_drive, 0);
        check("ack1_int_out", bus.interrupt_out, 0);
        bus.interrupt = 8'h01 << $urandom_range(0, 7);
        step();
        check("clr_pulse_end", bus.clear_interrupt_request, 0);
        bus.inta_low = 1'b0;
        step();
        step();
        check("ack1_int_hold", bus.interrupt_out, 0);
        bus.inta_low = 1'b1;
        step();
        check("ack2_drive", bus.data_bus_drive, 1);
        check("ack2_vector", bus.data_bus_out,
              bus.vector_base * 8 + lvl);
        step();
        check("ack2_drive_hold", bus.data_bus_drive, 1);
        bus.inta_low = 1'b0;
        step();
        if (aeoi && !sp) begin
            m_isr[lvl] = 1'b0;
            if (m_arot) m_rot = lvl;
        end
        check("ack_end_drive", bus.data_bus_drive, 0);
        check_state("ack_end");
        bus.interrupt = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_int_out"}, bus.interrupt_out, 0);
        check({tag, "_isr"}, bus.in_service_register, 0);
        check({tag, "_rot"}, bus.priority_rotate, 7);
        check({tag, "_clr"}, bus.clear_interrupt_request, 0);
        check({tag, "_dout"}, bus.data_bus_out, 0);
        check({tag, "_drive"}, bus.data_bus_drive, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8'h02, 8'h02, 3'd7};
        vecs[1]  = '{1'b1, 1'b0, 8'h10, 8'h12, 3'd7};
        vecs[2]  = '{1'b0, 1'b0, 8'h08, 8'h10, 3'd7};
        vecs[3]  = '{1'b0, 1'b0, 8'h1C, 8'h00, 3'd7};
        vecs[4]  = '{1'b0, 1'b0, 8'h08, 8'h00, 3'd7};
        vecs[5]  = '{1'b0, 1'b0, 8'h32, 8'h00, 3'd2};
        vecs[6]  = '{1'b1, 1'b0, 8'h02, 8'h02, 3'd2};
        vecs[7]  = '{1'b1, 1'b0, 8'h10, 8'h12, 3'd2};
        vecs[8]  = '{1'b0, 1'b0, 8'h28, 8'h02, 3'd4};
        vecs[9]  = '{1'b0, 1'b0, 8'h37, 8'h02, 3'd7};
        vecs[10] = '{1'b0, 1'b0, 8'h19, 8'h00, 3'd7};
        vecs[11] = '{1'b0, 1'b0, 8'h28, 8'h00, 3'd7};
        vecs[12] = '{1'b0, 1'b0, 8'h1D, 8'h00, 3'd7};
        vecs[13] = '{1'b0, 1'b0, 8'h20, 8'h00, 3'd7};
        vecs[14] = '{1'b1, 1'b1, 8'h08, 8'h00, 3'd3};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 8'h00, 3'd3};
        vecs[16] = '{1'b1, 1'b1, 8'h20, 8'h00, 3'd3};
        vecs[17] = '{1'b1, 1'b0, 8'h00, 8'h00, 3'd3};
        vecs[18] = '{1'b1, 1'b0, 8'h20, 8'h20, 3'd3};
        vecs[19] = '{1'b0, 1'b0, 8'h3D, 8'h00, 3'd5};
        vecs[20] = '{1'b0, 1'b0, 8'h10, 8'h00, 3'd5};

        reset           = 1'b1;
        bus.interrupt   = '0;
        bus.inta_low    = 1'b0;
        bus.vector_base = 5'b01000;
        bus.auto_eoi    = 1'b0;
        bus.ocw2_valid  = 1'b0;
        bus.ocw2_cmd    = '0;
        bus.ocw2_level  = '0;
        model_reset();
        step();
        step();
        check_reset_values("rst");
        reset = 1'b0;
        step();
        check_reset_values("post_rst");

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].is_ack)
                ack(vecs[i].data, vecs[i].aeoi);
            else
                ocw(vecs[i].data[5:3], vecs[i].data[2:0]);
            check($sformatf("vec%0d_isr", i),
                  bus.in_service_register, vecs[i].exp_isr);
            check($sformatf("vec%0d_rot", i),
                  bus.priority_rotate, vecs[i].exp_rot);
        end

        // OCW2 clear of the bit being set in the same cycle
        bus.auto_eoi  = 1'b0;
        bus.interrupt = 8'h04;
        step();
        bus.inta_low   = 1'b1;
        bus.ocw2_valid = 1'b1;
        bus.ocw2_cmd   = 3'b011;
        bus.ocw2_level = 3'd2;
        step();
        bus.ocw2_valid = 1'b0;
        m_isr[2] = 1'b1;
        check("same_cycle_set", bus.in_service_register, 8'h04);
        bus.interrupt = '0;
        bus.inta_low  = 1'b0;
        step();
        step();
        bus.inta_low = 1'b1;
        step();
        check("same_cycle_vec", bus.data_bus_out, 8'h42);
        bus.inta_low = 1'b0;
        step();
        ocw(3'b011, 3'd2);

        // asynchronous reset while the vector is on the bus
        bus.interrupt = 8'h10;
        step();
        bus.inta_low = 1'b1;
        step();
        bus.interrupt = '0;
        bus.inta_low  = 1'b0;
        step();
        step();
        bus.inta_low = 1'b1;
        step();
        check("pre_rst_drive", bus.data_bus_drive, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        step();
        bus.inta_low = 1'b0;
        reset        = 1'b0;
        model_reset();
        step();
        ack(8'h02, 1'b0);
        ocw(3'b011, 3'd1);

        for (int n = 0; n < 300; n++) begin
            bus.vector_base = 5'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    ack(8'h00, 1'($urandom));
                else
                    ack(8'h01 << $urandom_range(0, 7),
                        1'($urandom));
            end else begin
                ocw(3'($urandom), 3'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
